// File: rtl/reg_f_pkg.sv
// Shared index constants and context-operation decode for the reg_f_ctx register file.
package reg_f_pkg;

  localparam int unsigned RF_IDX_ZERO  = 0;
  localparam int unsigned RF_IDX_ONES  = 1;
  localparam int unsigned RF_IDX_ACC   = 2;
  localparam int unsigned RF_IDX_WORK0 = 3;

  // Requested context-stack operation for one cycle
  typedef enum logic [1:0] {
    CtxNone,
    CtxPush,
    CtxPop,
    CtxColl
  } ctx_op_e;

  function automatic ctx_op_e ctx_decode(input logic push, input logic pop);
    ctx_op_e op;
    unique case ({push, pop})
      2'b10:   op = CtxPush;
      2'b01:   op = CtxPop;
      2'b11:   op = CtxColl;
      default: op = CtxNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_f_ctx_stack.sv
// Context frame stack: DEPTH frames of the ACC+work window, written at level, read at level-1.
module reg_f_ctx_stack #(
  parameter int unsigned FW    = 72,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [FW-1:0]              i_frame,
  output logic [FW-1:0]              o_frame,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned LW  = $clog2(DEPTH + 1);
  localparam int unsigned SAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FW-1:0]  r_mem [DEPTH];
  logic [LW-1:0]  r_level;
  logic [SAW-1:0] w_wr_idx;
  logic [SAW-1:0] w_rd_idx;

  // Index the frame slots; the read index wraps when empty but is then never consumed
  always_comb begin
    w_wr_idx = SAW'(r_level);
    w_rd_idx = SAW'(r_level - LW'(1));
  end

  // Frame storage is intentionally not reset; level==0 makes stale frames unreachable
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_frame;
    end
  end

  // Stack pointer; the caller only asserts push when not full and pop when not empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else if (i_push) begin
      r_level <= r_level + LW'(1);
    end else if (i_pop) begin
      r_level <= r_level - LW'(1);
    end
  end

  // Status outputs and asynchronous top-of-stack read
  always_comb begin
    o_frame = r_mem[w_rd_idx];
    o_level = r_level;
    o_full  = (r_level == LW'(DEPTH));
    o_empty = (r_level == '0);
  end

endmodule

// File: rtl/reg_f_ctx.sv
// Register file with constant regs, ACC, work regs and a save/restore context stack.
module reg_f_ctx
  import reg_f_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 11,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NREGS)-1:0]   rf_addr_r1,
  output logic [WIDTH-1:0]           rf_data_out1,
  input  logic [$clog2(NREGS)-1:0]   rf_addr_r2,
  output logic [WIDTH-1:0]           rf_data_out2,
  input  logic [$clog2(NREGS)-1:0]   rf_addr_wr,
  input  logic                       rf_data_we,
  input  logic [WIDTH-1:0]           rf_data_in,
  input  logic                       rf_ctx_push,
  input  logic                       rf_ctx_pop,
  input  logic                       rf_err_clr,
  output logic [$clog2(DEPTH+1)-1:0] rf_ctx_level,
  output logic                       rf_ctx_full,
  output logic                       rf_ctx_empty,
  output logic                       rf_err_ovf,
  output logic                       rf_err_unf,
  output logic                       rf_err_coll,
  output logic                       rf_acc_zero
);

  localparam int unsigned FW = (NREGS - 2) * WIDTH;

  logic [WIDTH-1:0]       r_regs [RF_IDX_ACC:NREGS-1];
  logic                   r_err_ovf;
  logic                   r_err_unf;
  logic                   r_err_coll;

  logic [NREGS*WIDTH-1:0] w_file;
  logic [FW-1:0]          w_win;
  logic [FW-1:0]          w_top;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_wr_hit;
  ctx_op_e                w_op;
  logic                   w_push_ok;
  logic                   w_pop_ok;
  logic                   w_set_ovf;
  logic                   w_set_unf;
  logic                   w_set_coll;

  // Flatten constants plus live registers so reads and the push window share one view
  always_comb begin
    w_file = '0;
    w_file[RF_IDX_ONES*WIDTH +: WIDTH] = '1;
    for (int unsigned k = RF_IDX_ACC; k < NREGS; k++) begin
      w_file[k*WIDTH +: WIDTH] = r_regs[k];
    end
    w_win = w_file[NREGS*WIDTH-1 : RF_IDX_ACC*WIDTH];
  end

  // Combinational read ports; out-of-range addresses read zero
  always_comb begin
    rf_data_out1 = '0;
    rf_data_out2 = '0;
    if (32'(rf_addr_r1) < NREGS) rf_data_out1 = w_file[32'(rf_addr_r1)*WIDTH +: WIDTH];
    if (32'(rf_addr_r2) < NREGS) rf_data_out2 = w_file[32'(rf_addr_r2)*WIDTH +: WIDTH];
  end

  // Decode the stack request into legal operations and error events
  always_comb begin
    w_op       = ctx_decode(rf_ctx_push, rf_ctx_pop);
    w_push_ok  = 1'b0;
    w_pop_ok   = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    w_set_coll = 1'b0;
    unique case (w_op)
      CtxPush: begin
        w_push_ok = !w_full;
        w_set_ovf = w_full;
      end
      CtxPop: begin
        w_pop_ok  = !w_empty;
        w_set_unf = w_empty;
      end
      CtxColl: w_set_coll = 1'b1;
      default: ;
    endcase
    w_wr_hit = rf_data_we && (32'(rf_addr_wr) >= RF_IDX_ACC) && (32'(rf_addr_wr) < NREGS);
  end

  // Register array: a successful pop overrides any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = RF_IDX_ACC; k < NREGS; k++) r_regs[k] <= '0;
    end else if (w_pop_ok) begin
      for (int unsigned k = RF_IDX_ACC; k < NREGS; k++) begin
        r_regs[k] <= w_top[(k-RF_IDX_ACC)*WIDTH +: WIDTH];
      end
    end else if (w_wr_hit) begin
      for (int unsigned k = RF_IDX_ACC; k < NREGS; k++) begin
        if (32'(rf_addr_wr) == k) r_regs[k] <= rf_data_in;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps its flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
      r_err_coll <= 1'b0;
    end else begin
      r_err_ovf  <= (r_err_ovf  && !rf_err_clr) || w_set_ovf;
      r_err_unf  <= (r_err_unf  && !rf_err_clr) || w_set_unf;
      r_err_coll <= (r_err_coll && !rf_err_clr) || w_set_coll;
    end
  end

  reg_f_ctx_stack #(
    .FW    (FW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_pop   (w_pop_ok),
    .i_frame (w_win),
    .o_frame (w_top),
    .o_level (rf_ctx_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Status outputs
  always_comb begin
    rf_ctx_full  = w_full;
    rf_ctx_empty = w_empty;
    rf_err_ovf   = r_err_ovf;
    rf_err_unf   = r_err_unf;
    rf_err_coll  = r_err_coll;
    rf_acc_zero  = (r_regs[RF_IDX_ACC] == '0);
  end

endmodule

// File: tb/tb_reg_f_ctx.sv
// Directed self-checking bench for reg_f_ctx: vector table plus multi-cycle stack sequences.
module tb_reg_f_ctx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREGS = 11;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a1, a2, wa;
  logic [7:0] d1, d2, wd;
  logic       we, push, pop, clr;
  logic [4:0] level;
  logic       full, empty, ovf, unf, coll, accz;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_f_ctx #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rf_addr_r1   (a1),
    .rf_data_out1 (d1),
    .rf_addr_r2   (a2),
    .rf_data_out2 (d2),
    .rf_addr_wr   (wa),
    .rf_data_we   (we),
    .rf_data_in   (wd),
    .rf_ctx_push  (push),
    .rf_ctx_pop   (pop),
    .rf_err_clr   (clr),
    .rf_ctx_level (level),
    .rf_ctx_full  (full),
    .rf_ctx_empty (empty),
    .rf_err_ovf   (ovf),
    .rf_err_unf   (unf),
    .rf_err_coll  (coll),
    .rf_acc_zero  (accz)
  );

  // Flags packed as {full, empty, ovf, unf, coll, acc_zero}
  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       push, pop, clr;
    logic [3:0] a1, a2;
    logic [7:0] e1, e2;
    logic [4:0] el;
    logic [5:0] ef;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic w, input logic [3:0] wadr, input logic [7:0] wdat,
                              input logic ps, input logic pp, input logic cl,
                              input logic [3:0] r1, input logic [3:0] r2,
                              input logic [7:0] x1, input logic [7:0] x2,
                              input logic [4:0] xl, input logic [5:0] xf);
    vec_t v;
    v.we = w; v.wa = wadr; v.wd = wdat; v.push = ps; v.pop = pp; v.clr = cl;
    v.a1 = r1; v.a2 = r2; v.e1 = x1; v.e2 = x2; v.el = xl; v.ef = xf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {full, empty, ovf, unf, coll, accz};
  endfunction

  // Advance one clock and settle past the edge before sampling
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; push = 0; pop = 0; clr = 0;
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 1,  8'h00, 8'hFF, 0, 6'b010001);
    tbl[1]  = mk(0, 0, 8'h00, 0, 0, 0, 2, 15, 8'h00, 8'h00, 0, 6'b010001);
    tbl[2]  = mk(1, 2, 8'h5A, 0, 0, 0, 2, 3,  8'h5A, 8'h00, 0, 6'b010000);
    tbl[3]  = mk(1, 3, 8'h11, 0, 0, 0, 2, 3,  8'h5A, 8'h11, 0, 6'b010000);
    tbl[4]  = mk(0, 0, 8'h00, 1, 0, 0, 2, 3,  8'h5A, 8'h11, 1, 6'b000000);
    tbl[5]  = mk(1, 2, 8'h00, 0, 0, 0, 2, 3,  8'h00, 8'h11, 1, 6'b000001);
    tbl[6]  = mk(0, 0, 8'h00, 0, 1, 0, 2, 3,  8'h5A, 8'h11, 0, 6'b010000);
    tbl[7]  = mk(0, 0, 8'h00, 0, 1, 0, 2, 3,  8'h5A, 8'h11, 0, 6'b010100);
    tbl[8]  = mk(0, 0, 8'h00, 0, 0, 1, 2, 3,  8'h5A, 8'h11, 0, 6'b010000);
    tbl[9]  = mk(0, 0, 8'h00, 1, 1, 0, 2, 3,  8'h5A, 8'h11, 0, 6'b010010);
    tbl[10] = mk(0, 0, 8'h00, 1, 1, 1, 2, 3,  8'h5A, 8'h11, 0, 6'b010010);
    tbl[11] = mk(0, 0, 8'h00, 0, 0, 1, 2, 3,  8'h5A, 8'h11, 0, 6'b010000);
    tbl[12] = mk(1, 2, 8'h22, 0, 0, 0, 2, 3,  8'h22, 8'h11, 0, 6'b010000);
    tbl[13] = mk(1, 2, 8'h33, 1, 0, 0, 2, 3,  8'h33, 8'h11, 1, 6'b000000);
    tbl[14] = mk(0, 0, 8'h00, 0, 1, 0, 2, 3,  8'h22, 8'h11, 0, 6'b010000);
    tbl[15] = mk(0, 0, 8'h00, 1, 0, 0, 2, 3,  8'h22, 8'h11, 1, 6'b000000);
    tbl[16] = mk(1, 2, 8'h44, 0, 1, 0, 2, 3,  8'h22, 8'h11, 0, 6'b010000);
    tbl[17] = mk(1, 0, 8'hAB, 0, 0, 0, 0, 1,  8'h00, 8'hFF, 0, 6'b010000);
    tbl[18] = mk(1, 1, 8'hCD, 0, 0, 0, 0, 1,  8'h00, 8'hFF, 0, 6'b010000);
    tbl[19] = mk(1, 12, 8'h77, 0, 0, 0, 12, 2, 8'h00, 8'h22, 0, 6'b010000);
    tbl[20] = mk(1, 2, 8'h66, 0, 1, 0, 2, 3,  8'h66, 8'h11, 0, 6'b010100);
    tbl[21] = mk(0, 0, 8'h00, 0, 0, 1, 2, 3,  8'h66, 8'h11, 0, 6'b010000);

    idle();
    a1 = 0; a2 = 0;
    rst = 1;
    cyc();
    cyc();
    rst = 0;

    foreach (tbl[i]) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      push = tbl[i].push; pop = tbl[i].pop; clr = tbl[i].clr;
      a1 = tbl[i].a1; a2 = tbl[i].a2;
      cyc();
      check($sformatf("v%0d_out1", i), 32'(d1), 32'(tbl[i].e1));
      check($sformatf("v%0d_out2", i), 32'(d2), 32'(tbl[i].e2));
      check($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].el));
      check($sformatf("v%0d_flags", i), 32'(flags()), 32'(tbl[i].ef));
    end
    idle();

    // Fill the stack with distinct ACC values, then overflow
    a1 = 2; a2 = 3;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wa = 2; wd = 8'(8'h80 + i);
      cyc();
      we = 0; push = 1;
      cyc();
      push = 0;
      check($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf_pre", 32'(ovf), 32'd0);
    we = 1; wa = 2; wd = 8'hEE; push = 1;
    cyc();
    idle();
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_level", 32'(level), 32'(DEPTH));
    check("ovf_write_applied", 32'(d1), 32'h0EE);

    // Drain in LIFO order
    for (int j = 0; j < DEPTH; j++) begin
      pop = 1;
      cyc();
      pop = 0;
      check($sformatf("drain%0d_acc", j), 32'(d1), 32'(8'h80 + DEPTH - 1 - j));
      check($sformatf("drain%0d_level", j), 32'(level), 32'(DEPTH - 1 - j));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_r0", 32'(d2), 32'h011);
    clr = 1;
    cyc();
    idle();
    check("clr_ovf", 32'(ovf), 32'd0);

    // Back-to-back push/pop/push at full rate
    push = 1; cyc(); check("b2b_l1", 32'(level), 32'd1);
    push = 0; pop = 1; cyc(); check("b2b_l0", 32'(level), 32'd0);
    pop = 0; push = 1; cyc(); check("b2b_l1b", 32'(level), 32'd1);
    push = 1; cyc();
    push = 1; cyc(); check("pre_rst_level", 32'(level), 32'd3);
    pop = 1; cyc();
    idle();
    check("pre_rst_coll", 32'(coll), 32'd1);

    // Reset coinciding with push and write wins
    rst = 1; push = 1; we = 1; wa = 2; wd = 8'h99;
    cyc();
    rst = 0;
    idle();
    check("rst_level", 32'(level), 32'd0);
    check("rst_flags", 32'(flags()), 32'(6'b010001));
    check("rst_acc", 32'(d1), 32'd0);
    check("rst_r0", 32'(d2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
